// File: rtl/logic_gate_pipe_if.sv
// Valid/ready stream bundle for logic_gate_pipe: operand side in, result side out.
// The DUT uses the slave modport; the producer/consumer uses the master modport.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_any;
  logic             out_all;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_any, out_all, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_any, out_all, out_count
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise 2-input gate unit: selectable function on WIDTH-bit operands,
// carried through STAGES bubble-collapsing valid/ready register stages.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst_n,
  logic_gate_pipe_if.slave bus
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_gate_pipe: STAGES must be in 1..4");
  end

  logic [WIDTH-1:0] gate_y;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0] d [STAGES];
  logic [STAGES:0]  adv;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    gate_y = '0;
    case (bus.in_op)
      3'd0: gate_y = bus.in_a & bus.in_b;
      3'd1: gate_y = bus.in_a | bus.in_b;
      3'd2: gate_y = ~(bus.in_a & bus.in_b);
      3'd3: gate_y = ~(bus.in_a | bus.in_b);
      3'd4: gate_y = bus.in_a ^ bus.in_b;
      3'd5: gate_y = ~(bus.in_a ^ bus.in_b);
      3'd6: gate_y = ~bus.in_a;
      3'd7: gate_y = bus.in_a;
      default: gate_y = '0;
    endcase
  end

  // A stage may load when it is empty or its successor is moving on.
  always_comb begin
    adv = '0;
    adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !v[k] | adv[k+1];
    end
  end

  // Loading an invalid slot writes zero data, so empty stages always hold 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= bus.in_valid;
        d[0] <= bus.in_valid ? gate_y : '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          d[k] <= v[k-1] ? d[k-1] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (v[STAGES-1] && bus.out_ready && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_y     = d[STAGES-1];
  assign bus.out_any   = |d[STAGES-1];
  assign bus.out_all   = &d[STAGES-1];
  assign bus.out_count = cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: a STAGES=2/CNT_W=16 and a STAGES=1/CNT_W=4 instance share
// stimulus; a queue-position model is checked every cycle plus literal expectations.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(4))  bus1 ();

  logic_gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  logic_gate_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int total = 0;
  int passed = 0;

  // Model: each instance holds an ordered list of results and the stage index each occupies.
  logic [7:0] m_data [2][4];
  int         m_pos  [2][4];
  int         m_n    [2];
  int         m_cnt  [2];
  logic [7:0] got [$];

  function automatic int stagesOf(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int maxCnt(int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic logic [7:0] gateModel(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] y;
    case (op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0111;
      3'd3: tt = 4'b0001;
      3'd4: tt = 4'b0110;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int j = 0; j < 8; j++) y[j] = tt[{a[j], b[j]}];
    return y;
  endfunction

  function automatic int lastNewPos(int i, logic ordy);
    int s = stagesOf(i);
    int ahead = s;
    int first = 0;
    int np;
    if (m_n[i] > 0 && m_pos[i][0] == s - 1 && ordy) first = 1;
    for (int j = first; j < m_n[i]; j++) begin
      np = (m_pos[i][j] + 1 < ahead - 1) ? m_pos[i][j] + 1 : ahead - 1;
      ahead = np;
    end
    return ahead;
  endfunction

  task automatic modelStep(int i, logic valid, logic [7:0] a, logic [7:0] b,
                           logic [2:0] op, logic ordy);
    int s = stagesOf(i);
    int ahead = s;
    int np;
    if (m_n[i] > 0 && m_pos[i][0] == s - 1 && ordy) begin
      for (int j = 0; j < m_n[i] - 1; j++) begin
        m_data[i][j] = m_data[i][j+1];
        m_pos[i][j]  = m_pos[i][j+1];
      end
      m_n[i]--;
      if (m_cnt[i] < maxCnt(i)) m_cnt[i]++;
    end
    for (int j = 0; j < m_n[i]; j++) begin
      np = (m_pos[i][j] + 1 < ahead - 1) ? m_pos[i][j] + 1 : ahead - 1;
      m_pos[i][j] = np;
      ahead = np;
    end
    if (valid && ahead > 0) begin
      m_data[i][m_n[i]] = gateModel(op, a, b);
      m_pos[i][m_n[i]]  = 0;
      m_n[i]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i] = 0;
        m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        modelStep(i, bus0.in_valid, bus0.in_a, bus0.in_b, bus0.in_op, bus0.out_ready);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic compareInst(int i, logic inr, logic ov, logic [7:0] y,
                             logic any, logic all, logic [31:0] cnt);
    logic       ev;
    logic [7:0] ey;
    ev = (m_n[i] > 0) && (m_pos[i][0] == stagesOf(i) - 1);
    ey = ev ? m_data[i][0] : 8'h00;
    checkOutput($sformatf("p%0d.in_ready", i), 32'(inr), 32'(lastNewPos(i, bus0.out_ready) > 0));
    checkOutput($sformatf("p%0d.out_valid", i), 32'(ov), 32'(ev));
    checkOutput($sformatf("p%0d.out_y", i), 32'(y), 32'(ey));
    checkOutput($sformatf("p%0d.out_any", i), 32'(any), 32'(ey != 8'h00));
    checkOutput($sformatf("p%0d.out_all", i), 32'(all), 32'(ey == 8'hFF));
    checkOutput($sformatf("p%0d.out_count", i), cnt, 32'(m_cnt[i]));
  endtask

  always @(negedge clk) begin
    compareInst(0, bus0.in_ready, bus0.out_valid, bus0.out_y, bus0.out_any,
                bus0.out_all, 32'(bus0.out_count));
    compareInst(1, bus1.in_ready, bus1.out_valid, bus1.out_y, bus1.out_any,
                bus1.out_all, 32'(bus1.out_count));
    if (rst_n && bus0.out_valid && bus0.out_ready) got.push_back(bus0.out_y);
  end

  task automatic setInputs(logic valid, logic [7:0] a, logic [7:0] b, logic [2:0] op, logic ordy);
    bus0.in_valid = valid; bus0.in_a = a; bus0.in_b = b; bus0.in_op = op; bus0.out_ready = ordy;
    bus1.in_valid = valid; bus1.in_a = a; bus1.in_b = b; bus1.in_op = op; bus1.out_ready = ordy;
  endtask

  task automatic applyStimulus(logic valid, logic [7:0] a, logic [7:0] b, logic [2:0] op, logic ordy);
    setInputs(valid, a, b, op, ordy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp1 [8];
    exp1 = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    setInputs(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("reset.in_ready", 32'(bus0.in_ready), 32'd1);
    checkOutput("reset.out_count", 32'(bus0.out_count), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // All eight functions on F0/CC, checking the two latencies on the first one.
    got.delete();
    applyStimulus(1'b1, 8'hF0, 8'hCC, 3'd0, 1'b1);
    checkOutput("lat2.early", 32'(bus0.out_valid), 32'd0);
    checkOutput("lat1.valid", 32'(bus1.out_valid), 32'd1);
    checkOutput("lat1.y", 32'(bus1.out_y), 32'hC0);
    applyStimulus(1'b1, 8'hF0, 8'hCC, 3'd1, 1'b1);
    checkOutput("lat2.valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("lat2.y", 32'(bus0.out_y), 32'hC0);
    for (int op = 2; op < 8; op++) applyStimulus(1'b1, 8'hF0, 8'hCC, 3'(op), 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("ops.count", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      checkOutput($sformatf("ops.y%0d", k), 32'(got[k]), 32'(exp1[k]));
    checkOutput("ops.out_count", 32'(bus0.out_count), 32'd8);

    // Backpressure: two buffered, third refused, then drain in order.
    got.delete();
    applyStimulus(1'b1, 8'h11, 8'h00, 3'd7, 1'b0);
    applyStimulus(1'b1, 8'h22, 8'h00, 3'd7, 1'b0);
    setInputs(1'b1, 8'h33, 8'h00, 3'd7, 1'b0);
    #1;
    checkOutput("bp.in_ready", 32'(bus0.in_ready), 32'd0);
    checkOutput("bp.y", 32'(bus0.out_y), 32'h11);
    @(posedge clk); #1;
    checkOutput("bp.hold", 32'(bus0.out_y), 32'h11);
    setInputs(1'b1, 8'h33, 8'h00, 3'd7, 1'b1);
    #1;
    checkOutput("full.in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("drain.y1", 32'(bus0.out_y), 32'h22);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("drain.size", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      checkOutput("drain.first", 32'(got[0]), 32'h11);
      checkOutput("drain.second", 32'(got[1]), 32'h22);
    end
    checkOutput("drain.out_count", 32'(bus0.out_count), 32'd10);
    checkOutput("drain.pending", 32'(bus0.out_y), 32'h33);

    // Full pipe with simultaneous accept and delivery keeps occupancy at two.
    applyStimulus(1'b1, 8'h44, 8'h00, 3'd7, 1'b0);
    setInputs(1'b1, 8'h55, 8'h00, 3'd7, 1'b1);
    #1;
    checkOutput("flow.in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("flow.y", 32'(bus0.out_y), 32'h44);
    setInputs(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    #1;
    checkOutput("flow.still_full", 32'(bus0.in_ready), 32'd0);
    @(posedge clk); #1;
    repeat (3) applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Reduction flags at the all-ones and all-zeros extremes.
    applyStimulus(1'b1, 8'h00, 8'h00, 3'd3, 1'b1);
    applyStimulus(1'b1, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("nor.y", 32'(bus0.out_y), 32'hFF);
    checkOutput("nor.all", 32'(bus0.out_all), 32'd1);
    checkOutput("nor.any", 32'(bus0.out_any), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("and.valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("and.y", 32'(bus0.out_y), 32'h00);
    checkOutput("and.any", 32'(bus0.out_any), 32'd0);
    checkOutput("and.all", 32'(bus0.out_all), 32'd0);
    repeat (2) applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Asynchronous reset with two results in flight.
    applyStimulus(1'b1, 8'hA5, 8'h5A, 3'd4, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'h0F, 3'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("arst.out_count", 32'(bus0.out_count), 32'd0);
    checkOutput("arst.out_y", 32'(bus0.out_y), 32'h00);
    checkOutput("arst.in_ready", 32'(bus0.in_ready), 32'd1);
    setInputs(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete();
    repeat (4) applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("arst.no_stale", 32'(got.size()), 32'd0);

    // Twenty back-to-back transactions saturate the 4-bit counter.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 8'(i * 7), ~8'(i), 3'(i % 8), 1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    checkOutput("sat.count4", 32'(bus1.out_count), 32'd15);
    checkOutput("sat.count16", 32'(bus0.out_count), 32'd20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
